// File: rtl/text_console_master.sv
// ----------------------------------------------------------------------------
// text_console_master
//
// Bus master that turns a stream of ASCII bytes into single-cell writes on an
// 80x30 text-mode video card. Keeps a cursor and handles CR, LF and backspace.
// Cell index is row*80+col.
//
// Optional feature macro: CONSOLE_SCROLL_EN
//   defined   : when the cursor would move past row 29 the screen is scrolled
//               up by one row (read cell i+80, write it to cell i, then blank
//               the last row) before new bytes are accepted.
//   undefined : row overflow wraps the cursor to row 0 without any bus
//               traffic; the scroll states and capture register do not exist.
//
// Ports
//   clk         system clock, all state changes on the rising edge
//   reset       synchronous active-low reset
//   char_in     ASCII byte to print
//   char_valid  char_in is valid
//   char_ready  byte taken on an edge where char_valid and char_ready are 1
//   STB         bus strobe to the video card
//   WE          bus write enable, meaningful while STB is 1
//   ADDR        cell index 0..2399 (bits 31:12 always 0)
//   DAT_O       write data {16'h0, 8'h00, ascii}
//   DAT_I       read data from the card, bits 15:0 used
//   ACK         registered acknowledge from the card
//   busy        1 whenever the FSM is not idle
//   cursor_col  current column 0..79
//   cursor_row  current row 0..29
// ----------------------------------------------------------------------------
module text_console_master (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  char_in,
   input  logic        char_valid,
   output logic        char_ready,
   output logic        STB,
   output logic        WE,
   output logic [31:0] ADDR,
   output logic [31:0] DAT_O,
   input  logic [31:0] DAT_I,
   input  logic        ACK,
   output logic        busy,
   output logic [6:0]  cursor_col,
   output logic [4:0]  cursor_row
);

   localparam logic [6:0]  LastCol  = 7'd79;
   localparam logic [4:0]  LastRow  = 5'd29;
   localparam logic [15:0] BlankDat = 16'h0020;

`ifdef CONSOLE_SCROLL_EN
   localparam logic [11:0] RowCells = 12'd80;
   localparam logic [11:0] LastCopy = 12'd2319;
   localparam logic [11:0] LastCell = 12'd2399;

   typedef enum logic [2:0] {StIdle, StPut, StRd, StWr, StClr, StGap} state_e;
`else
   typedef enum logic [1:0] {StIdle, StPut, StGap} state_e;
`endif

   state_e      state_q, state_d;
   // State to enter once the card has dropped ACK after a bus cycle.
   state_e      ret_q, ret_d;
   logic        rdy_q;
   logic [6:0]  col_q, col_d;
   logic [4:0]  row_q, row_d;
   logic        stb_q, stb_d;
   logic        we_q, we_d;
   logic [11:0] addr_q, addr_d;
   logic [15:0] dat_q, dat_d;
   // Printable bytes advance the cursor after their write; backspace does not.
   logic        adv_q, adv_d;
   logic        accept;

`ifdef CONSOLE_SCROLL_EN
   logic [11:0] idx_q, idx_d;
   logic [15:0] cap_q, cap_d;
   logic        unused_dat;
   assign unused_dat = ^DAT_I[31:16];
`else
   logic        unused_dat;
   assign unused_dat = ^DAT_I;
`endif

   // row*80 + col as row*64 + row*16 + col; max 2399 fits in 12 bits.
   function automatic logic [11:0] cell_addr(input logic [4:0] row, input logic [6:0] col);
      cell_addr = {1'b0, row, 6'b0} + {3'b0, row, 4'b0} + {5'b0, col};
   endfunction

   // rdy_q is only ever 1 while idle, and stays 0 on the cycle of reset.
   assign accept = char_valid & rdy_q;

   always_comb begin
      state_d = state_q;
      ret_d   = ret_q;
      col_d   = col_q;
      row_d   = row_q;
      stb_d   = stb_q;
      we_d    = we_q;
      addr_d  = addr_q;
      dat_d   = dat_q;
      adv_d   = adv_q;
`ifdef CONSOLE_SCROLL_EN
      idx_d   = idx_q;
      cap_d   = cap_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (char_in >= 8'h20 && char_in <= 8'h7E) begin
                  dat_d   = {8'h00, char_in};
                  adv_d   = 1'b1;
                  state_d = StPut;
               end else if (char_in == 8'h0A) begin
                  col_d = '0;
                  if (row_q == LastRow) begin
`ifdef CONSOLE_SCROLL_EN
                     idx_d   = '0;
                     state_d = StRd;
`else
                     row_d = '0;
`endif
                  end else begin
                     row_d = row_q + 5'd1;
                  end
               end else if (char_in == 8'h0D) begin
                  col_d = '0;
               end else if (char_in == 8'h08) begin
                  if (col_q != 7'd0) begin
                     col_d   = col_q - 7'd1;
                     dat_d   = BlankDat;
                     adv_d   = 1'b0;
                     state_d = StPut;
                  end
               end
            end
         end

         StPut: begin
            if (!stb_q) begin
               // col_q already holds the target column (decremented for BS).
               stb_d  = 1'b1;
               we_d   = 1'b1;
               addr_d = cell_addr(row_q, col_q);
            end else if (ACK) begin
               stb_d   = 1'b0;
               state_d = StGap;
               ret_d   = StIdle;
               if (adv_q) begin
                  if (col_q == LastCol) begin
                     col_d = '0;
                     if (row_q == LastRow) begin
`ifdef CONSOLE_SCROLL_EN
                        idx_d = '0;
                        ret_d = StRd;
`else
                        row_d = '0;
`endif
                     end else begin
                        row_d = row_q + 5'd1;
                     end
                  end else begin
                     col_d = col_q + 7'd1;
                  end
               end
            end
         end

`ifdef CONSOLE_SCROLL_EN
         StRd: begin
            if (!stb_q) begin
               stb_d  = 1'b1;
               we_d   = 1'b0;
               addr_d = idx_q + RowCells;
            end else if (ACK) begin
               stb_d   = 1'b0;
               cap_d   = DAT_I[15:0];
               ret_d   = StWr;
               state_d = StGap;
            end
         end

         StWr: begin
            if (!stb_q) begin
               stb_d  = 1'b1;
               we_d   = 1'b1;
               addr_d = idx_q;
               dat_d  = cap_q;
            end else if (ACK) begin
               stb_d   = 1'b0;
               idx_d   = idx_q + 12'd1;
               ret_d   = (idx_q == LastCopy) ? StClr : StRd;
               state_d = StGap;
            end
         end

         StClr: begin
            if (!stb_q) begin
               stb_d  = 1'b1;
               we_d   = 1'b1;
               addr_d = idx_q;
               dat_d  = BlankDat;
            end else if (ACK) begin
               stb_d   = 1'b0;
               state_d = StGap;
               if (idx_q == LastCell) begin
                  ret_d = StIdle;
                  row_d = LastRow;
                  col_d = '0;
               end else begin
                  idx_d = idx_q + 12'd1;
                  ret_d = StClr;
               end
            end
         end
`endif

         StGap: begin
            // Next strobe only after the card's ACK has been seen low.
            if (!ACK) begin
               state_d = ret_q;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StIdle;
         ret_q   <= StIdle;
         rdy_q   <= 1'b0;
         col_q   <= '0;
         row_q   <= '0;
         stb_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         dat_q   <= '0;
         adv_q   <= 1'b0;
`ifdef CONSOLE_SCROLL_EN
         idx_q   <= '0;
         cap_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         rdy_q   <= (state_d == StIdle);
         col_q   <= col_d;
         row_q   <= row_d;
         stb_q   <= stb_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         dat_q   <= dat_d;
         adv_q   <= adv_d;
`ifdef CONSOLE_SCROLL_EN
         idx_q   <= idx_d;
         cap_q   <= cap_d;
`endif
      end
   end

   assign char_ready = rdy_q;
   assign STB        = stb_q;
   assign WE         = we_q;
   assign ADDR       = {20'h0, addr_q};
   assign DAT_O      = {16'h0, dat_q};
   assign busy       = (state_q != StIdle);
   assign cursor_col = col_q;
   assign cursor_row = row_q;

endmodule

// File: tb/tb_text_console_master.sv
// ----------------------------------------------------------------------------
// Bench for text_console_master. A behavioural video card answers each strobe
// with a one-cycle registered ACK. Stimulus pushes the expected bus cycles into
// a queue; an independent monitor pops and compares them as the DUT completes
// each cycle.
// ----------------------------------------------------------------------------
module tb_text_console_master;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  char_in = 8'h00;
   logic        char_valid = 1'b0;
   logic        char_ready;
   logic        STB;
   logic        WE;
   logic [31:0] ADDR;
   logic [31:0] DAT_O;
   logic [31:0] DAT_I;
   logic        ACK;
   logic        busy;
   logic [6:0]  cursor_col;
   logic [4:0]  cursor_row;

   always #5 clk = ~clk;

   text_console_master dut (
      .clk        (clk),
      .reset      (reset),
      .char_in    (char_in),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .STB        (STB),
      .WE         (WE),
      .ADDR       (ADDR),
      .DAT_O      (DAT_O),
      .DAT_I      (DAT_I),
      .ACK        (ACK),
      .busy       (busy),
      .cursor_col (cursor_col),
      .cursor_row (cursor_row)
   );

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] dat;
   } bus_t;

   bus_t        sb_q[$];
   logic [15:0] card_mem [0:2399];
   logic [15:0] exp_scr  [0:2399];
   logic        ack_r;
   logic [31:0] rd_r;
   int          n_chk = 0;
   int          n_pass = 0;
   int          stb_cnt = 0;
   bit          mon_en = 1'b1;

   assign ACK   = ack_r;
   assign DAT_I = rd_r;

   function automatic logic [15:0] pat(input int i);
      return 16'h3000 + 16'(i);
   endfunction

   // Video card: ACK one cycle after the strobe is seen, data registered with it.
   always @(posedge clk) begin
      if (!reset) begin
         ack_r <= 1'b0;
         rd_r  <= 32'h0;
         for (int i = 0; i < 2400; i++) card_mem[i] <= pat(i);
      end else begin
         ack_r <= STB & ~ack_r;
         if (STB && !ack_r && ADDR < 32'd2400) begin
            if (WE) card_mem[ADDR[11:0]] <= DAT_O[15:0];
            else    rd_r <= {16'h0, card_mem[ADDR[11:0]]};
         end
      end
   end

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", name, act, exp);
   endtask

   task automatic push(input logic we, input int addr, input logic [15:0] d);
      bus_t e;
      e.we   = we;
      e.addr = 32'(addr);
      e.dat  = we ? {16'h0, d} : 32'h0;
      sb_q.push_back(e);
      if (we) exp_scr[addr] = d;
   endtask

`ifdef CONSOLE_SCROLL_EN
   task automatic push_scroll();
      for (int i = 0; i < 2320; i++) begin
         push(1'b0, i + 80, 16'h0);
         push(1'b1, i, exp_scr[i + 80]);
      end
      for (int i = 2320; i < 2400; i++) push(1'b1, i, 16'h0020);
   endtask
`endif

   // Monitor: one comparison per completed bus cycle plus hold/width checks.
   initial begin : monitor
      bus_t        e;
      int          stb_len;
      logic        prev_we;
      logic [31:0] prev_addr;
      logic [31:0] prev_dat;
      stb_len = 0;
      forever begin
         @(negedge clk);
         if (STB) stb_cnt++;
         if (!reset || !mon_en) begin
            stb_len = 0;
         end else if (STB) begin
            if (stb_len > 0)
               chk("bus_hold", 96'({WE, ADDR, DAT_O}), 96'({prev_we, prev_addr, prev_dat}));
            prev_we   = WE;
            prev_addr = ADDR;
            prev_dat  = DAT_O;
            stb_len++;
            if (ACK) begin
               chk("stb_width", 96'(stb_len), 96'd2);
               chk("bus_expected", 96'(sb_q.size() != 0), 96'd1);
               if (sb_q.size() != 0) begin
                  e = sb_q.pop_front();
                  chk("bus_xfer", 96'({WE, ADDR, (WE ? DAT_O : 32'h0)}),
                      96'({e.we, e.addr, e.dat}));
               end
               stb_len = 0;
            end
         end
      end
   end

   task automatic send(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      char_in    = b;
      char_valid = 1'b1;
      while (!char_ready && n < 60000) begin
         @(negedge clk);
         n++;
      end
      if (!char_ready) chk("send_timeout", 96'd0, 96'd1);
      @(posedge clk);
      #1 char_valid = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      @(negedge clk);
      while (!char_ready && n < limit) begin
         @(negedge clk);
         n++;
      end
      chk("idle_reached", 96'(char_ready), 96'd1);
      chk("sb_drained", 96'(sb_q.size()), 96'd0);
   endtask

   task automatic cur(input string name, input int c, input int r);
      chk(name, 96'({cursor_row, cursor_col}), 96'(r * 128 + c));
   endtask

   // Entered at a negedge; reset is sampled from the following posedge.
   task automatic do_reset(input int n);
      reset      = 1'b0;
      char_valid = 1'b0;
      sb_q.delete();
      for (int i = 0; i < 2400; i++) exp_scr[i] = pat(i);
      repeat (n) begin
         @(negedge clk);
         chk("rst_outputs", 96'({STB, WE, ADDR, DAT_O, char_ready, busy, cursor_col,
                                 cursor_row}), 96'd0);
      end
      reset = 1'b1;
      @(negedge clk);
      chk("rst_release_ready", 96'(char_ready), 96'd1);
      chk("rst_release_state", 96'({STB, busy, cursor_col, cursor_row}), 96'd0);
   endtask

   initial begin : watchdog
      #4000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin : main
      int s;
      int mism;
      int t;
      logic [15:0] saved80;

      do_reset(2);

      // Single printable byte with cycle-exact handshake timing.
      push(1'b1, 0, 16'h0041);
      @(negedge clk);
      char_in    = 8'h41;
      char_valid = 1'b1;
      @(posedge clk);
      #1 char_valid = 1'b0;
      @(negedge clk) chk("lat_t0", 96'({STB, busy, char_ready}), 96'b010);
      @(negedge clk) chk("lat_t1", 96'(STB), 96'd1);
      @(negedge clk) chk("lat_t2", 96'(STB), 96'd1);
      @(negedge clk) chk("lat_t3", 96'({STB, char_ready}), 96'b00);
      @(negedge clk) chk("lat_t4", 96'(char_ready), 96'd1);
      cur("cur_after_A", 1, 0);
      chk("sb_after_A", 96'(sb_q.size()), 96'd0);

      // Full row of 'B' wraps to the next row; back-space at col 0 is a no-op.
      send(8'h0D);
      wait_idle(100);
      cur("cur_after_cr", 0, 0);
      for (int i = 0; i < 80; i++) begin
         push(1'b1, i, 16'h0042);
         send(8'h42);
      end
      wait_idle(100);
      cur("cur_after_row", 0, 1);
      s = stb_cnt;
      send(8'h08);
      wait_idle(100);
      cur("cur_bs_col0", 0, 1);
      chk("bs_col0_nobus", 96'(stb_cnt - s), 96'd0);

      // Move to (5,3), back-space blanks cell 244, CR returns to col 0.
      send(8'h0A);
      send(8'h0A);
      for (int i = 0; i < 5; i++) begin
         push(1'b1, 240 + i, 16'h0043);
         send(8'h43);
      end
      wait_idle(100);
      cur("cur_5_3", 5, 3);
      push(1'b1, 244, 16'h0020);
      send(8'h08);
      wait_idle(100);
      cur("cur_after_bs", 4, 3);
      s = stb_cnt;
      send(8'h0D);
      wait_idle(100);
      cur("cur_after_cr3", 0, 3);
      chk("cr_nobus", 96'(stb_cnt - s), 96'd0);

      // Printable range edges, then bytes that must be swallowed.
      push(1'b1, 240, 16'h0020);
      send(8'h20);
      push(1'b1, 241, 16'h007E);
      send(8'h7E);
      wait_idle(100);
      cur("cur_edges", 2, 3);
      s = stb_cnt;
      send(8'h1F);
      send(8'h7F);
      send(8'h80);
      send(8'hFF);
      send(8'h09);
      wait_idle(100);
      cur("cur_ignored", 2, 3);
      chk("ignored_nobus", 96'(stb_cnt - s), 96'd0);

      // Line-feed overflow from row 29.
      for (int i = 0; i < 26; i++) send(8'h0A);
      wait_idle(100);
      cur("cur_row29", 0, 29);
`ifdef CONSOLE_SCROLL_EN
      saved80 = exp_scr[80];
      push_scroll();
      send(8'h0A);
      wait_idle(60000);
      cur("cur_after_lf_scroll", 0, 29);
      chk("scroll_cell0", 96'(card_mem[0]), 96'(saved80));
      chk("scroll_cell2399", 96'(card_mem[2399]), 96'h20);
`else
      saved80 = 16'h0;
      s = stb_cnt;
      send(8'h0A);
      wait_idle(100);
      cur("cur_after_lf_wrap", 0, 0);
      chk("lf_wrap_nobus", 96'(stb_cnt - s), 96'(saved80));
      for (int i = 0; i < 29; i++) send(8'h0A);
      wait_idle(100);
      cur("cur_row29_again", 0, 29);
`endif

      // Column-wrap overflow on the last row.
      for (int i = 0; i < 79; i++) begin
         push(1'b1, 2320 + i, 16'h0045);
         send(8'h45);
      end
      wait_idle(100);
      cur("cur_79_29", 79, 29);
      push(1'b1, 2399, 16'h0046);
`ifdef CONSOLE_SCROLL_EN
      push_scroll();
      send(8'h46);
      wait_idle(60000);
      cur("cur_after_wrap_scroll", 0, 29);

      // Reset in the middle of a scroll.
      mon_en = 1'b0;
      send(8'h0A);
      repeat (300) @(negedge clk);
      t = 0;
      while (!STB && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("midscroll_stb_up", 96'(STB), 96'd1);
      do_reset(2);
      mon_en = 1'b1;
      s = stb_cnt;
      repeat (50) @(negedge clk);
      chk("midscroll_nobus", 96'(stb_cnt - s), 96'd0);
      cur("cur_after_midscroll", 0, 0);
`else
      send(8'h46);
      wait_idle(100);
      cur("cur_after_wrap", 0, 0);
`endif

      // Reset while a write strobe is up.
      @(negedge clk);
      char_in    = 8'h47;
      char_valid = 1'b1;
      @(posedge clk);
      #1 char_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("midcycle_stb_up", 96'(STB), 96'd1);
      do_reset(2);
      s = stb_cnt;
      repeat (20) @(negedge clk);
      chk("midcycle_nobus", 96'(stb_cnt - s), 96'd0);
      cur("cur_after_midcycle", 0, 0);

      push(1'b1, 0, 16'h0048);
      send(8'h48);
      wait_idle(100);
      cur("cur_after_H", 1, 0);

      mism = 0;
      for (int i = 0; i < 2400; i++) if (card_mem[i] !== exp_scr[i]) mism++;
      chk("screen_contents", 96'(mism), 96'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/text_console_master.md
TEXT_CONSOLE_MASTER -- requirements
Module: text_console_master

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset: clk and reset.
REQ-002 Port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1 bit: synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 Port char_in, input, 8 bits: ASCII byte to print.
REQ-005 Port char_valid, input, 1 bit: char_in is valid.
REQ-006 Port char_ready, output, 1 bit: byte accepted on a rising edge where char_valid and char_ready are both 1.
REQ-007 Port STB, output, 1 bit: bus strobe to the video card.
REQ-008 Port WE, output, 1 bit: bus write enable, valid while STB is 1.
REQ-009 Port ADDR, output, 32 bits: cell index 0..2399, computed as row*80+col; bits 31:12 are always 0.
REQ-010 Port DAT_O, output, 32 bits: write data {16'h0, 8'h00, ascii}.
REQ-011 Port DAT_I, input, 32 bits: read data from the card; bits 15:0 are used.
REQ-012 Port ACK, input, 1 bit: registered acknowledge from the card.
REQ-013 Port busy, output, 1 bit: 1 in any state other than IDLE.
REQ-014 Port cursor_col, output, 7 bits: current column, 0..79.
REQ-015 Port cursor_row, output, 5 bits: current row, 0..29.

Function
REQ-016 The FSM SHALL have the states IDLE, PUT, RD, WR, CLR and GAP; char_ready SHALL be 1 only in IDLE.
REQ-017 On an accepted byte 0x20..0x7E, the block SHALL go to PUT and issue one write of the byte at the cursor, then advance col; col 80 SHALL set col to 0 and increment row.
REQ-018 For 0x0A, the block SHALL set col to 0 and increment row, with no bus cycle; for 0x0D, it SHALL set col to 0, with no bus cycle.
REQ-019 For 0x08 with col>0, the block SHALL decrement col and then write 0x0020 at the new col; for 0x08 with col=0, it SHALL do nothing.
REQ-020 All other bytes SHALL be consumed and ignored; the cursor SHALL not change.
REQ-021 Bus cycle rules:
- STB, WE, ADDR and DAT_O are registered and held stable while STB is 1.
- On the edge where ACK=1 is sampled, STB is cleared.
- A new STB is raised only after ACK=0 is sampled (GAP state).
REQ-022 Latency for a printable byte accepted at edge T, with the card's 1-cycle ACK:
- STB=1 from T+1.
- ACK sampled at T+3, so STB=0 after T+3.
- ACK=0 sampled at T+4, so char_ready=1 after T+4.
REQ-023 For a read (WE=0), DAT_I[15:0] SHALL be captured on the edge where ACK=1 is sampled.
REQ-024 Row overflow (row would become 30) SHALL trigger a scroll before IDLE is re-entered:
- For i = 0..2319: RD cell i+80, then WR the captured value to cell i.
- CLR: write 0x0020 to cells 2320..2399.
- Then set row=29, col=0.
REQ-025 Overflow caused by 0x0A, or by col wrap, SHALL be handled identically.
REQ-026 A char_valid asserted while busy SHALL be held off, with no loss and no duplication.

Reset
REQ-027 While reset=0 at an edge, the block SHALL set:
- STB=0, WE=0, ADDR=0, DAT_O=0.
- cursor_col=0, cursor_row=0, busy=0, char_ready=0, state IDLE.
REQ-028 char_ready SHALL be 1 from the first edge with reset=1.
REQ-029 A reset mid-cycle or mid-scroll SHALL drop STB at that edge and abandon the operation; no further bus cycles SHALL occur.

Configuration
REQ-030 The macro CONSOLE_SCROLL_EN SHALL select the row-overflow behaviour:
- Defined: overflow scrolls per REQ-024.
- Undefined: overflow sets row=0 with no bus cycles, the RD/WR/CLR states and the capture register are omitted, and cursor_col behaves identically.

Verification
REQ-031 Scenario: reset low for 2 cycles, then release -> STB=0, cursor (0,0), char_ready=1 one cycle after release.
REQ-032 Scenario: send 0x41 at (0,0) -> one write, ADDR=0, DAT_O=0x00000041, WE=1; cursor (1,0); STB high exactly until ACK is sampled.
REQ-033 Scenario: 80 bytes of 0x42 -> ADDRs 0..79 written; cursor (0,1); then 0x08 -> no bus cycle, cursor unchanged.
REQ-034 Scenario: cursor (5,3), send 0x08 -> write ADDR=244 with 0x0020; cursor (4,3); then 0x0D -> cursor (0,3), no bus cycle.
REQ-035 Scenario: row 29, send 0x0A with CONSOLE_SCROLL_EN defined -> 2320 RD/WR pairs, then 80 writes of 0x0020 to 2320..2399; cell 0 equals the prior cell 80; cursor (0,29); without the macro -> cursor (0,0), no bus cycles.
REQ-036 Scenario: reset asserted mid-scroll -> STB=0 at the next edge, no further bus cycles, cursor (0,0).
